// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 timing constants, counter types and control bundle for vga_scanout
package vga_pkg;

  // Counter types: both counters fit in 10 bits (max 799 and 524)
  typedef logic [9:0] hcnt_t;
  typedef logic [9:0] vcnt_t;

  // Horizontal timing, in pixel clocks
  localparam hcnt_t H_VISIBLE    = 10'd640;
  localparam hcnt_t H_FRONT      = 10'd16;
  localparam hcnt_t H_SYNC       = 10'd96;
  localparam hcnt_t H_BACK       = 10'd48;
  localparam hcnt_t H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam hcnt_t H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam hcnt_t H_SYNC_END   = H_SYNC_START + H_SYNC - 10'd1;

  // Vertical timing, in lines
  localparam vcnt_t V_VISIBLE    = 10'd480;
  localparam vcnt_t V_FRONT      = 10'd10;
  localparam vcnt_t V_SYNC       = 10'd2;
  localparam vcnt_t V_BACK       = 10'd33;
  localparam vcnt_t V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam vcnt_t V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam vcnt_t V_SYNC_END   = V_SYNC_START + V_SYNC - 10'd1;

  // Control signals that travel down the alignment pipeline together
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
    logic frame_start;
  } vga_ctl_t;

  // Idle value of the control bundle: syncs are active-low, so idle high
  localparam vga_ctl_t CTL_IDLE = '{hsync: 1'b1, vsync: 1'b1, active: 1'b0, frame_start: 1'b0};

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - free-running h/v counters and raw (undelayed) sync/active decode
module vga_timing
  import vga_pkg::*;
(
  input  logic  clock,
  input  logic  reset_n,
  output hcnt_t h,
  output vcnt_t v,
  output logic  h_wrap,
  output logic  hsync_raw,
  output logic  vsync_raw,
  output logic  active_raw,
  output logic  frame_start_raw
);

  hcnt_t h_q, h_d;
  vcnt_t v_q, v_d;
  logic  h_last;
  logic  v_last;

  // Next-count logic: h wraps every line, v advances on the h wrap
  always_comb begin
    h_last = (h_q == H_TOTAL - 10'd1);
    v_last = (v_q == V_TOTAL - 10'd1);
    h_d    = h_last ? '0 : h_q + 10'd1;
    v_d    = v_q;
    if (h_last) begin
      v_d = v_last ? '0 : v_q + 10'd1;
    end
  end

  // Counter registers; reset restarts the frame at (0,0)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Raw decode straight from the counters; the top delays these to meet the pixel
  always_comb begin
    hsync_raw       = !((h_q >= H_SYNC_START) && (h_q <= H_SYNC_END));
    vsync_raw       = !((v_q >= V_SYNC_START) && (v_q <= V_SYNC_END));
    active_raw      = (h_q < H_VISIBLE) && (v_q < V_VISIBLE);
    frame_start_raw = (h_q == '0) && (v_q == '0);
  end

  assign h      = h_q;
  assign v      = v_q;
  assign h_wrap = h_last;

endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - upscaling framebuffer scanout; VGA_SCANOUT_TESTPAT_EN adds a pattern_sel checkerboard
module vga_scanout
  import vga_pkg::*;
#(
  parameter int DATA_WIDTH  = 1,
  parameter int ADDR_WIDTH  = 15,
  parameter int FB_WIDTH    = 160,
  parameter int FB_HEIGHT   = 120,
  parameter int SCALE_SHIFT = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
`ifdef VGA_SCANOUT_TESTPAT_EN
  input  logic                  pattern_sel,
`endif
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] q,
  output logic                  hsync,
  output logic                  vsync,
  output logic [DATA_WIDTH-1:0] pixel,
  output logic                  video_active,
  output logic                  frame_start
);

  // Framebuffer geometry in address units
  localparam logic [ADDR_WIDTH-1:0] FB_STRIDE = ADDR_WIDTH'(FB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] FB_LAST   = ADDR_WIDTH'(FB_WIDTH * FB_HEIGHT - 1);
  // A new framebuffer row starts every 2^SCALE_SHIFT screen lines
  localparam vcnt_t SCALE_MASK    = vcnt_t'((1 << SCALE_SHIFT) - 1);
  localparam vcnt_t LAST_VIS_LINE = V_VISIBLE - 10'd1;

  hcnt_t    h;
  vcnt_t    v;
  logic     h_wrap;
  vga_ctl_t ctl_raw;

  vga_timing u_timing (
    .clock           (clock),
    .reset_n         (reset_n),
    .h               (h),
    .v               (v),
    .h_wrap          (h_wrap),
    .hsync_raw       (ctl_raw.hsync),
    .vsync_raw       (ctl_raw.vsync),
    .active_raw      (ctl_raw.active),
    .frame_start_raw (ctl_raw.frame_start)
  );

  logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;
  logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d;
  logic [ADDR_WIDTH-1:0] next_base;
  logic [ADDR_WIDTH-1:0] fetch_x;
  logic [ADDR_WIDTH-1:0] raw_addr;
  logic                  advance;

  // Address generation: line_base steps by FB_WIDTH instead of multiplying v;
  // blanking fetches the next line's base so its first pixel is ready at h=0
  always_comb begin
    fetch_x = ADDR_WIDTH'(h >> SCALE_SHIFT);
    advance = (((v + 10'd1) & SCALE_MASK) == '0) && (v < LAST_VIS_LINE);
    if (v == V_TOTAL - 10'd1) begin
      next_base = '0;
    end else if (advance) begin
      next_base = line_base_q + FB_STRIDE;
    end else begin
      next_base = line_base_q;
    end
    raw_addr    = ctl_raw.active ? (line_base_q + fetch_x) : next_base;
    // Clamp guards against odd parameter combinations overrunning the buffer
    read_addr_d = (raw_addr > FB_LAST) ? FB_LAST : raw_addr;
    line_base_d = h_wrap ? next_base : line_base_q;
  end

  // Address registers: read_addr trails the counters by one clock
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      line_base_q <= '0;
      read_addr_q <= '0;
    end else begin
      line_base_q <= line_base_d;
      read_addr_q <= read_addr_d;
    end
  end

  vga_ctl_t ctl_s1_q, ctl_s1_d;
  vga_ctl_t ctl_s2_q, ctl_s2_d;

  // Alignment pipeline next state: one stage for the address, one for RAM latency
  always_comb begin
    ctl_s1_d = ctl_raw;
    ctl_s2_d = ctl_s1_q;
  end

  // Alignment pipeline registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctl_s1_q <= CTL_IDLE;
      ctl_s2_q <= CTL_IDLE;
    end else begin
      ctl_s1_q <= ctl_s1_d;
      ctl_s2_q <= ctl_s2_d;
    end
  end

  logic [DATA_WIDTH-1:0] pix_src;

`ifdef VGA_SCANOUT_TESTPAT_EN
  logic tile_s1_q, tile_s1_d;
  logic tile_s2_q, tile_s2_d;

  // Checkerboard tile select: 32-pixel screen squares, i.e. 8x8 framebuffer texels
  always_comb begin
    tile_s1_d = h[5] ^ v[5];
    tile_s2_d = tile_s1_q;
  end

  // Tile select travels with the control bundle so it lands on the same pixel
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tile_s1_q <= 1'b0;
      tile_s2_q <= 1'b0;
    end else begin
      tile_s1_q <= tile_s1_d;
      tile_s2_q <= tile_s2_d;
    end
  end

  // Pixel source: test pattern overrides framebuffer data
  always_comb begin
    pix_src = q;
    if (pattern_sel) begin
      pix_src = tile_s2_q ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
    end
  end
`else
  // Pixel source: framebuffer data only
  always_comb begin
    pix_src = q;
  end
`endif

  // Output blanking: nothing but black outside the visible area
  always_comb begin
    pixel = ctl_s2_q.active ? pix_src : {DATA_WIDTH{1'b0}};
  end

  assign read_addr    = read_addr_q;
  assign hsync        = ctl_s2_q.hsync;
  assign vsync        = ctl_s2_q.vsync;
  assign video_active = ctl_s2_q.active;
  assign frame_start  = ctl_s2_q.frame_start;

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - directed self-checking bench for vga_scanout
module tb_vga_scanout;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [14:0] read_addr;
  logic [0:0]  q;
  logic        hsync;
  logic        vsync;
  logic [0:0]  pixel;
  logic        video_active;
  logic        frame_start;
`ifdef VGA_SCANOUT_TESTPAT_EN
  logic        pattern_sel;
`endif

  int cmp = 0;
  int bad = 0;
  int n   = 0;

  logic [0:0] fb [0:19199];

  always #5 clock = ~clock;

  vga_scanout dut (
    .clock        (clock),
    .reset_n      (reset_n),
`ifdef VGA_SCANOUT_TESTPAT_EN
    .pattern_sel  (pattern_sel),
`endif
    .read_addr    (read_addr),
    .q            (q),
    .hsync        (hsync),
    .vsync        (vsync),
    .pixel        (pixel),
    .video_active (video_active),
    .frame_start  (frame_start)
  );

  // Framebuffer with one clock of read latency
  always @(posedge clock) begin
    q <= (read_addr < 15'd19200) ? fb[read_addr] : 1'b0;
  end

  task automatic step();
    @(posedge clock);
    #1;
    n = n + 1;
  endtask

  task automatic check_reset_values(input string tag);
    cmp++; if (read_addr !== 15'd0) begin bad++; $display("FAIL %s read_addr got %0d want 0", tag, read_addr); end
    cmp++; if (hsync !== 1'b1) begin bad++; $display("FAIL %s hsync got %b want 1", tag, hsync); end
    cmp++; if (vsync !== 1'b1) begin bad++; $display("FAIL %s vsync got %b want 1", tag, vsync); end
    cmp++; if (pixel !== 1'b0) begin bad++; $display("FAIL %s pixel got %b want 0", tag, pixel); end
    cmp++; if (video_active !== 1'b0) begin bad++; $display("FAIL %s video_active got %b want 0", tag, video_active); end
    cmp++; if (frame_start !== 1'b0) begin bad++; $display("FAIL %s frame_start got %b want 0", tag, frame_start); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_values("reset");
    @(negedge clock);
    reset_n = 1'b1;
    n = 0;
    step();
    cmp++; if (frame_start !== 1'b0) begin bad++; $display("FAIL fs_edge1 got %b want 0", frame_start); end
    cmp++; if (read_addr !== 15'd0) begin bad++; $display("FAIL first_fetch got %0d want 0", read_addr); end
    step();
    cmp++; if (frame_start !== 1'b1) begin bad++; $display("FAIL fs_edge2 got %b want 1", frame_start); end
    cmp++; if (video_active !== 1'b1) begin bad++; $display("FAIL active_at_origin got %b want 1", video_active); end
  endtask

  // One full frame, outputs at n correspond to screen position n-2, read_addr to n-1
  task automatic test_frame();
    int p, x, y, pa, xa, ya;
    int hs_bad, vs_bad, act_bad, fs_bad, pix_bad;
    int hs_low, hs_low0, first_hs, vs_low, fs_cnt, max_addr;
    logic e_hs, e_vs, e_act, e_fs, e_pix;
    hs_bad = 0; vs_bad = 0; act_bad = 0; fs_bad = 0; pix_bad = 0;
    hs_low = 0; hs_low0 = 0; first_hs = -1; vs_low = 0; fs_cnt = 0; max_addr = 0;
    for (int k = 0; k < 420000; k++) begin
      if (k > 0) step();
      p = n - 2;
      x = p % 800;
      y = p / 800;
      e_hs  = !(x >= 656 && x <= 751);
      e_vs  = !(y >= 490 && y <= 491);
      e_act = (x < 640) && (y < 480);
      e_fs  = (x == 0) && (y == 0);
      e_pix = e_act && !(x >= 160 && x <= 479 && y >= 120 && y <= 359);
      if (hsync !== e_hs) hs_bad++;
      if (vsync !== e_vs) vs_bad++;
      if (video_active !== e_act) act_bad++;
      if (frame_start !== e_fs) fs_bad++;
      if (pixel !== e_pix) pix_bad++;
      if (hsync === 1'b0) begin
        hs_low++;
        if (y == 0) hs_low0++;
        if (first_hs < 0) first_hs = n;
      end
      if (vsync === 1'b0) vs_low++;
      if (frame_start === 1'b1) fs_cnt++;
      if (int'(read_addr) > max_addr) max_addr = int'(read_addr);
      pa = p + 1;
      xa = pa % 800;
      ya = pa / 800;
      if (xa == 639 && ya == 479) begin
        cmp++; if (read_addr !== 15'd19199) begin bad++; $display("FAIL addr_639_479 got %0d want 19199", read_addr); end
      end
      if (xa == 0 && ya == 4) begin
        cmp++; if (read_addr !== 15'd160) begin bad++; $display("FAIL addr_0_4 got %0d want 160", read_addr); end
      end
      if (xa == 700 && ya == 3) begin
        cmp++; if (read_addr !== 15'd160) begin bad++; $display("FAIL addr_blank_line3 got %0d want 160", read_addr); end
      end
    end
    cmp++; if (hs_bad != 0) begin bad++; $display("FAIL hsync_pattern got %0d bad cycles want 0", hs_bad); end
    cmp++; if (vs_bad != 0) begin bad++; $display("FAIL vsync_pattern got %0d bad cycles want 0", vs_bad); end
    cmp++; if (act_bad != 0) begin bad++; $display("FAIL active_pattern got %0d bad cycles want 0", act_bad); end
    cmp++; if (fs_bad != 0) begin bad++; $display("FAIL fs_pattern got %0d bad cycles want 0", fs_bad); end
    cmp++; if (pix_bad != 0) begin bad++; $display("FAIL rect_pixels got %0d bad pixels want 0", pix_bad); end
    cmp++; if (hs_low0 != 96) begin bad++; $display("FAIL hsync_low_line0 got %0d want 96", hs_low0); end
    cmp++; if (hs_low != 50400) begin bad++; $display("FAIL hsync_low_frame got %0d want 50400", hs_low); end
    cmp++; if (first_hs != 658) begin bad++; $display("FAIL hsync_first_low got %0d want 658", first_hs); end
    cmp++; if (vs_low != 1600) begin bad++; $display("FAIL vsync_low got %0d want 1600", vs_low); end
    cmp++; if (fs_cnt != 1) begin bad++; $display("FAIL fs_per_frame got %0d want 1", fs_cnt); end
    cmp++; if (max_addr != 19199) begin bad++; $display("FAIL max_addr got %0d want 19199", max_addr); end
    step();
    cmp++; if (frame_start !== 1'b1) begin bad++; $display("FAIL fs_period got %b want 1", frame_start); end
  endtask

  // Counters reach (300,200) of the second frame at n = 420000 + 200*800 + 300
  task automatic test_mid_reset();
    int rst_bad;
    rst_bad = 0;
    while (n < 580300) step();
    cmp++; if (video_active !== 1'b1) begin bad++; $display("FAIL pre_reset_active got %b want 1", video_active); end
    reset_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    repeat (3) begin
      @(posedge clock);
      #1;
      if (read_addr !== 15'd0 || hsync !== 1'b1 || vsync !== 1'b1 || pixel !== 1'b0 ||
          video_active !== 1'b0 || frame_start !== 1'b0) rst_bad++;
    end
    cmp++; if (rst_bad != 0) begin bad++; $display("FAIL reset_hold got %0d bad cycles want 0", rst_bad); end
    @(negedge clock);
    reset_n = 1'b1;
    n = 0;
    step();
    cmp++; if (read_addr !== 15'd0) begin bad++; $display("FAIL restart_fetch got %0d want 0", read_addr); end
    step();
    cmp++; if (frame_start !== 1'b1) begin bad++; $display("FAIL restart_fs got %b want 1", frame_start); end
    cmp++; if (pixel !== 1'b1) begin bad++; $display("FAIL restart_pixel got %b want 1", pixel); end
    while (n < 5) step();
    cmp++; if (read_addr !== 15'd1) begin bad++; $display("FAIL restart_addr_h4 got %0d want 1", read_addr); end
  endtask

`ifdef VGA_SCANOUT_TESTPAT_EN
  task automatic test_pattern();
    pattern_sel = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    n = 0;
    while (n < 2) step();
    cmp++; if (pixel !== 1'b0) begin bad++; $display("FAIL pat_0_0 got %b want 0", pixel); end
    while (n < 34) step();
    cmp++; if (pixel !== 1'b1) begin bad++; $display("FAIL pat_32_0 got %b want 1", pixel); end
    while (n < 25634) step();
    cmp++; if (pixel !== 1'b0) begin bad++; $display("FAIL pat_32_32 got %b want 0", pixel); end
    pattern_sel = 1'b0;
  endtask
`endif

  initial begin
    for (int yy = 0; yy < 120; yy++) begin
      for (int xx = 0; xx < 160; xx++) begin
        fb[yy * 160 + xx] = (xx >= 40 && xx <= 119 && yy >= 30 && yy <= 89) ? 1'b0 : 1'b1;
      end
    end
`ifdef VGA_SCANOUT_TESTPAT_EN
    pattern_sel = 1'b0;
`endif
    test_reset();
    test_frame();
    test_mid_reset();
`ifdef VGA_SCANOUT_TESTPAT_EN
    test_pattern();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
